// File: rtl/nyq_seq.sv
// Sequencer for the NYQ polyphase decimating filter: phase/MAC/shift strobes plus host write arbitration.
// Optional block counter output BlkCnt_DO is enabled by defining NYQ_SEQ_BLKCNT_EN.
module nyq_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter int DECIM      = 8,
  parameter int CNT_WIDTH  = 3,
  parameter int NUM_MACS   = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Start_SI,
  input  logic                  Stop_SI,
  input  logic                  SmpValid_SI,
  input  logic                  HostWrReq_SI,
  input  logic [ADDR_WIDTH-1:0] HostAddr_DI,
  output logic                  HostWrAck_SO,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [CNT_WIDTH-1:0]  Phase_DO,
  output logic                  MacEn_SO,
  output logic                  MacClr_SO,
  output logic                  Shift_SO,
  output logic                  OutValid_SO,
  output logic                  Busy_SO,
  output logic [1:0]            State_DO
`ifdef NYQ_SEQ_BLKCNT_EN
  ,
  output logic [15:0]           BlkCnt_DO
`endif
);

  localparam int FILL_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
  localparam logic [FILL_W-1:0]    FILL_MAX  = FILL_W'(NUM_MACS - 1);
  localparam logic [CNT_WIDTH-1:0] PHASE_MAX = CNT_WIDTH'(DECIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    CFG   = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  phaseCnt_q, phaseCnt_d;
  logic [FILL_W-1:0]     fillCnt_q, fillCnt_d;
  logic                  lastPend_q, lastPend_d;
  logic [CNT_WIDTH-1:0]  phase_q, phase_d;
  logic                  macEn_q, macEn_d;
  logic                  macClr_q, macClr_d;
  logic                  shift_q, shift_d;
  logic                  outValid_q, outValid_d;
  logic                  wrEn_q, wrEn_d;
  logic                  ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  accept;

  always_comb begin
    state_d    = state_q;
    phaseCnt_d = phaseCnt_q;
    fillCnt_d  = fillCnt_q;
    lastPend_d = 1'b0;
    phase_d    = phase_q;
    macEn_d    = 1'b0;
    macClr_d   = 1'b0;
    shift_d    = 1'b0;
    outValid_d = 1'b0;
    wrEn_d     = 1'b0;
    ack_d      = 1'b0;
    addr_d     = '0;
    accept     = 1'b0;

    // A block end seen last cycle always completes its shift, whatever the state does now
    if (lastPend_q) begin
      shift_d  = 1'b1;
      macClr_d = 1'b1;
      if (fillCnt_q == FILL_MAX) outValid_d = 1'b1;
      else                       fillCnt_d  = fillCnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        phaseCnt_d = '0;
        if (Start_SI) begin
          state_d   = RUN;
          macClr_d  = 1'b1;
          fillCnt_d = '0;
        end else if (HostWrReq_SI) begin
          state_d = CFG;
          wrEn_d  = 1'b1;
          ack_d   = 1'b1;
          addr_d  = HostAddr_DI;
        end
      end
      CFG: state_d = IDLE;
      RUN: begin
        if (Stop_SI && (phaseCnt_q == '0)) begin
          state_d = IDLE;
        end else begin
          if (Stop_SI) state_d = DRAIN;
          accept = SmpValid_SI;
        end
      end
      DRAIN: begin
        // The final phase has been taken once its block-end flag or shift is in flight
        if (shift_q) state_d = IDLE;
        else         accept  = SmpValid_SI && !lastPend_q;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      macEn_d    = 1'b1;
      phase_d    = phaseCnt_q;
      phaseCnt_d = phaseCnt_q + 1'b1;
      lastPend_d = (phaseCnt_q == PHASE_MAX);
    end else if ((state_d == IDLE) || (state_d == CFG)) begin
      phase_d = '0;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q    <= IDLE;
      phaseCnt_q <= '0;
      fillCnt_q  <= '0;
      lastPend_q <= 1'b0;
      phase_q    <= '0;
      macEn_q    <= 1'b0;
      macClr_q   <= 1'b0;
      shift_q    <= 1'b0;
      outValid_q <= 1'b0;
      wrEn_q     <= 1'b0;
      ack_q      <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phaseCnt_q <= phaseCnt_d;
      fillCnt_q  <= fillCnt_d;
      lastPend_q <= lastPend_d;
      phase_q    <= phase_d;
      macEn_q    <= macEn_d;
      macClr_q   <= macClr_d;
      shift_q    <= shift_d;
      outValid_q <= outValid_d;
      wrEn_q     <= wrEn_d;
      ack_q      <= ack_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
    end
  end

`ifdef NYQ_SEQ_BLKCNT_EN
  logic [15:0] blkCnt_q, blkCnt_d;

  always_comb begin
    blkCnt_d = blkCnt_q;
    if ((state_q == IDLE) && (state_d == RUN)) blkCnt_d = '0;
    else if (outValid_d)                       blkCnt_d = blkCnt_q + 16'd1;
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) blkCnt_q <= '0;
    else          blkCnt_q <= blkCnt_d;
  end

  assign BlkCnt_DO = blkCnt_q;
`endif

  assign HostWrAck_SO = ack_q;
  assign WrEn_SO      = wrEn_q;
  assign Addr_DO      = addr_q;
  assign Phase_DO     = phase_q;
  assign MacEn_SO     = macEn_q;
  assign MacClr_SO    = macClr_q;
  assign Shift_SO     = shift_q;
  assign OutValid_SO  = outValid_q;
  assign Busy_SO      = busy_q;
  assign State_DO     = state_q;

endmodule

// File: tb/tb_nyq_seq.sv
// Self-checking bench for nyq_seq: vector table for reset/host/drain basics, hand sequences for long runs.
// Checks BlkCnt_DO as well when NYQ_SEQ_BLKCNT_EN is defined.
module tb_nyq_seq;

  logic       Clk_CI;
  logic       Rst_RBI;
  logic       Start_SI;
  logic       Stop_SI;
  logic       SmpValid_SI;
  logic       HostWrReq_SI;
  logic [4:0] HostAddr_DI;
  logic       HostWrAck_SO;
  logic       WrEn_SO;
  logic [4:0] Addr_DO;
  logic [2:0] Phase_DO;
  logic       MacEn_SO;
  logic       MacClr_SO;
  logic       Shift_SO;
  logic       OutValid_SO;
  logic       Busy_SO;
  logic [1:0] State_DO;
`ifdef NYQ_SEQ_BLKCNT_EN
  logic [15:0] BlkCnt_DO;
`endif

  nyq_seq dut (
    .Clk_CI      (Clk_CI),
    .Rst_RBI     (Rst_RBI),
    .Start_SI    (Start_SI),
    .Stop_SI     (Stop_SI),
    .SmpValid_SI (SmpValid_SI),
    .HostWrReq_SI(HostWrReq_SI),
    .HostAddr_DI (HostAddr_DI),
    .HostWrAck_SO(HostWrAck_SO),
    .WrEn_SO     (WrEn_SO),
    .Addr_DO     (Addr_DO),
    .Phase_DO    (Phase_DO),
    .MacEn_SO    (MacEn_SO),
    .MacClr_SO   (MacClr_SO),
    .Shift_SO    (Shift_SO),
    .OutValid_SO (OutValid_SO),
    .Busy_SO     (Busy_SO),
    .State_DO    (State_DO)
`ifdef NYQ_SEQ_BLKCNT_EN
    ,
    .BlkCnt_DO   (BlkCnt_DO)
`endif
  );

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    logic [9:0]  stim;
    logic [16:0] expv;
  } vec_t;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2, ST_CFG = 3;

  vec_t tbl [25];
  int   errors = 0;
  int   checks = 0;

  // Reference model state for sample runs
  int   mCount, mShift, mPhase;
  logic mSeven;
  int   dutShift, dutOv;

  function automatic logic [16:0] mk(input int st, input int busy, input int ov, input int sh,
                                     input int clr, input int en, input int ph, input int ack,
                                     input int wr, input int ad);
    return {st[1:0], busy[0], ov[0], sh[0], clr[0], en[0], ph[2:0], ack[0], wr[0], ad[4:0]};
  endfunction

  function automatic logic [9:0] stim(input int rst, input int start, input int stop,
                                      input int smp, input int req, input int addr);
    return {rst[0], start[0], stop[0], smp[0], req[0], addr[4:0]};
  endfunction

  function automatic logic [16:0] packOut();
    return {State_DO, Busy_SO, OutValid_SO, Shift_SO, MacClr_SO, MacEn_SO, Phase_DO,
            HostWrAck_SO, WrEn_SO, Addr_DO};
  endfunction

  task automatic drive(input logic [9:0] s);
    Rst_RBI      = s[9];
    Start_SI     = s[8];
    Stop_SI      = s[7];
    SmpValid_SI  = s[6];
    HostWrReq_SI = s[5];
    HostAddr_DI  = s[4:0];
  endtask

  // Drive inputs, then move across one rising edge and land on the falling edge
  task automatic applyStimulus(input logic [9:0] s);
    drive(s);
    @(negedge Clk_CI);
  endtask

  task automatic checkOutput(input string name, input logic [16:0] expv);
    logic [16:0] act;
    act = packOut();
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d busy=%b ov=%b sh=%b clr=%b en=%b ph=%0d ack=%b wr=%b ad=%0d, expected st=%0d busy=%b ov=%b sh=%b clr=%b en=%b ph=%0d ack=%b wr=%b ad=%0d",
               name, act[16:15], act[14], act[13], act[12], act[11], act[10], act[9:7], act[6], act[5], act[4:0],
               expv[16:15], expv[14], expv[13], expv[12], expv[11], expv[10], expv[9:7], expv[6], expv[5], expv[4:0]);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic mStart();
    mCount   = 0;
    mShift   = 0;
    mPhase   = 0;
    mSeven   = 1'b0;
    dutShift = 0;
    dutOv    = 0;
  endtask

  // One busy-state cycle; expectations come from a block/phase model (NUM_MACS=4, DECIM=8)
  task automatic runCycle(input logic smp, input logic req, input int st, input string name);
    logic sh;
    logic ov;
    sh = mSeven;
    applyStimulus(stim(1, 0, 0, smp, req, 21));
    if (sh) mShift++;
    ov = sh && (mShift >= 4);
    if (smp) begin
      mPhase = mCount % 8;
      mSeven = (mPhase == 7);
      mCount++;
    end else begin
      mSeven = 1'b0;
    end
    dutShift += int'(Shift_SO);
    dutOv    += int'(OutValid_SO);
    checkOutput(name, mk(st, 1, ov, sh, sh, smp, mPhase, 0, 0, 0));
  endtask

  task automatic startRun(input string name);
    applyStimulus(stim(1, 1, 0, 0, 0, 0));
    checkOutput(name, mk(ST_RUN, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    mStart();
  endtask

  initial begin
    drive(stim(0, 0, 0, 0, 0, 0));

    // rst start stop smp req addr | st busy ov sh clr en ph ack wr ad
    tbl[0]  = '{stim(0,1,0,1,1,7),  mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[1]  = '{stim(0,0,1,1,1,3),  mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[2]  = '{stim(1,0,0,0,0,0),  mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[3]  = '{stim(1,0,0,0,0,0),  mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[4]  = '{stim(1,0,0,0,1,9),  mk(3,0,0,0,0,0,0,1,1,9)};
    tbl[5]  = '{stim(1,0,0,0,0,0),  mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[6]  = '{stim(1,0,0,0,1,4),  mk(3,0,0,0,0,0,0,1,1,4)};
    tbl[7]  = '{stim(1,0,0,0,1,5),  mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[8]  = '{stim(1,0,0,0,1,5),  mk(3,0,0,0,0,0,0,1,1,5)};
    tbl[9]  = '{stim(1,0,0,0,0,0),  mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[10] = '{stim(1,1,0,0,1,12), mk(1,1,0,0,1,0,0,0,0,0)};
    tbl[11] = '{stim(1,0,0,1,1,12), mk(1,1,0,0,0,1,0,0,0,0)};
    tbl[12] = '{stim(1,0,0,0,1,12), mk(1,1,0,0,0,0,0,0,0,0)};
    tbl[13] = '{stim(1,0,0,1,1,12), mk(1,1,0,0,0,1,1,0,0,0)};
    tbl[14] = '{stim(1,0,1,0,1,12), mk(2,1,0,0,0,0,1,0,0,0)};
    tbl[15] = '{stim(1,1,0,1,1,12), mk(2,1,0,0,0,1,2,0,0,0)};
    tbl[16] = '{stim(1,0,0,1,1,12), mk(2,1,0,0,0,1,3,0,0,0)};
    tbl[17] = '{stim(1,0,0,1,1,12), mk(2,1,0,0,0,1,4,0,0,0)};
    tbl[18] = '{stim(1,0,0,1,1,12), mk(2,1,0,0,0,1,5,0,0,0)};
    tbl[19] = '{stim(1,0,0,1,1,12), mk(2,1,0,0,0,1,6,0,0,0)};
    tbl[20] = '{stim(1,0,0,1,1,12), mk(2,1,0,0,0,1,7,0,0,0)};
    tbl[21] = '{stim(1,0,1,1,1,12), mk(2,1,0,1,1,0,7,0,0,0)};
    tbl[22] = '{stim(1,0,0,0,1,12), mk(0,0,0,0,0,0,0,0,0,0)};
    tbl[23] = '{stim(1,0,0,0,1,12), mk(3,0,0,0,0,0,0,1,1,12)};
    tbl[24] = '{stim(1,0,0,0,0,0),  mk(0,0,0,0,0,0,0,0,0,0)};

    for (int i = 0; i < 25; i++) begin
      applyStimulus(tbl[i].stim);
      checkOutput($sformatf("vec%0d", i), tbl[i].expv);
    end

    // 40 back-to-back samples: five blocks, output valid only on the 4th and 5th shift
    startRun("t3_start");
    for (int i = 0; i < 40; i++) runCycle(1'b1, 1'b0, ST_RUN, $sformatf("t3_smp%0d", i));
    runCycle(1'b0, 1'b0, ST_RUN, "t3_tail");
    checkVal("t3_shift_count", dutShift, 5);
    checkVal("t3_outvalid_count", dutOv, 2);
`ifdef NYQ_SEQ_BLKCNT_EN
    checkVal("t3_blkcnt", int'(BlkCnt_DO), 2);
`endif

    // Host request held through RUN is not acked, then served after a phase-0 stop
    for (int i = 0; i < 20; i++) runCycle(1'b0, 1'b1, ST_RUN, $sformatf("t4_hold%0d", i));
    applyStimulus(stim(1, 0, 1, 0, 1, 21));
    checkOutput("t4_stop_idle", mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(stim(1, 0, 0, 0, 1, 21));
    checkOutput("t4_cfg", mk(ST_CFG, 0, 0, 0, 0, 0, 0, 1, 1, 21));
    applyStimulus(stim(1, 0, 0, 0, 0, 0));
    checkOutput("t4_back_idle", mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Stop mid-block drains phases 3..7; a start pulse during drain is ignored
    startRun("t5_start");
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b0, ST_RUN, $sformatf("t5_smp%0d", i));
    applyStimulus(stim(1, 0, 1, 0, 0, 0));
    checkOutput("t5_drain", mk(ST_DRAIN, 1, 0, 0, 0, 0, 2, 0, 0, 0));
    applyStimulus(stim(1, 1, 0, 0, 0, 0));
    checkOutput("t5_start_ignored", mk(ST_DRAIN, 1, 0, 0, 0, 0, 2, 0, 0, 0));
    for (int i = 0; i < 5; i++) runCycle(1'b1, 1'b0, ST_DRAIN, $sformatf("t5_drain_smp%0d", i));
    runCycle(1'b0, 1'b0, ST_DRAIN, "t5_final_shift");
    applyStimulus(stim(1, 0, 0, 0, 0, 0));
    checkOutput("t5_idle", mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset mid-run at phase 5 (after two full blocks), then restart from a clean fill count
    startRun("t6_start");
    for (int i = 0; i < 21; i++) runCycle(1'b1, 1'b0, ST_RUN, $sformatf("t6_smp%0d", i));
    drive(stim(0, 0, 0, 1, 0, 0));
    #1;
    checkOutput("t6_no_edge_yet", mk(ST_RUN, 1, 0, 0, 0, 1, 4, 0, 0, 0));
    @(negedge Clk_CI);
    checkOutput("t6_reset", mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    startRun("t6_restart");
    for (int i = 0; i < 32; i++) runCycle(1'b1, 1'b0, ST_RUN, $sformatf("t6_run%0d", i));
    runCycle(1'b0, 1'b0, ST_RUN, "t6_tail");
    checkVal("t6_shift_count", dutShift, 4);
    checkVal("t6_outvalid_count", dutOv, 1);
`ifdef NYQ_SEQ_BLKCNT_EN
    checkVal("t6_blkcnt", int'(BlkCnt_DO), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
